// File: rtl/serial_adder.sv
// Bit-serial unsigned adder. Operands are shifted out LSB-first through one
// full-adder slice and a carry flop; sum and carry-out are loaded once at the end.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;

  logic s_bit;
  logic c_next;
  logic accept;

  // The single full-adder slice.
  assign s_bit  = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
  assign c_next = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);

  // A new request is taken in IDLE and also in DONE, giving back-to-back operation.
  assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;

    case (state_q)
      S_ADD: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        res_d   = {s_bit, res_q[WIDTH-1:1]};
        carry_d = c_next;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          sum_d   = {s_bit, res_q[WIDTH-1:1]};
          cout_d  = c_next;
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_IDLE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      a_sh_d  = a;
      b_sh_d  = b;
      carry_d = 1'b0;
      cnt_d   = '0;
      state_d = S_ADD;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == S_ADD);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed handshake cases plus
// random operands, with results predicted by plain integer addition.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         cout;

  int checks = 0;
  int errors = 0;

  // Last completed result; outputs must hold this until the next done.
  logic [W-1:0] exp_sum  = '0;
  logic         exp_cout = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One full operation. Starts anywhere away from an edge, ends #1 after the
  // edge that enters the done cycle. glitch>0 pulses start with AA/55 during
  // that busy cycle; hold keeps start high throughout.
  task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv,
                    input int glitch, input bit hold);
    logic [W:0] full;
    full  = {1'b0, av} + {1'b0, bv};
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    check("busy_rise", busy, 1);
    check("done_low_at_start", done, 0);
    for (int i = 2; i <= W; i++) begin
      if (i == glitch + 1) begin
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h55;
      end
      @(posedge clk); #1;
      if (i == glitch + 1 && !hold) start = 1'b0;
      check("busy_hold", busy, 1);
      check("done_low_busy", done, 0);
      check("sum_hold_busy", sum, exp_sum);
      check("cout_hold_busy", cout, exp_cout);
    end
    @(posedge clk); #1;
    exp_sum  = full[W-1:0];
    exp_cout = full[W];
    check("done_pulse", done, 1);
    check("busy_low_done", busy, 0);
    check("sum_result", sum, exp_sum);
    check("cout_result", cout, exp_cout);
  endtask

  task automatic idle_check(input int n);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_sum", sum, exp_sum);
      check("idle_cout", cout, exp_cout);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;

    // Reset state, then stay idle with start low.
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    @(negedge clk) rst_n = 1'b1;
    idle_check(4);

    // Directed arithmetic cases, including carry-out and all-zero.
    op(8'h35, 8'h4A, 0, 1'b0); idle_check(2);
    op(8'hFF, 8'h01, 0, 1'b0); idle_check(1);
    op(8'hFF, 8'hFF, 0, 1'b0); idle_check(1);
    op(8'h00, 8'h00, 0, 1'b0); idle_check(1);

    // Start pulse during busy cycle 3 must be ignored.
    op(8'h10, 8'h20, 3, 1'b0); idle_check(3);

    // Start held through busy and the done cycle: back-to-back, no idle gap.
    op(8'h13, 8'h57, 0, 1'b1);
    op(8'h80, 8'h80, 0, 1'b0); idle_check(2);

    // Asynchronous reset during ADD cycle 4.
    a     = 8'h77;
    b     = 8'h66;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    exp_sum  = '0;
    exp_cout = 1'b0;
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    check("async_rst_sum", sum, 0);
    check("async_rst_cout", cout, 0);
    repeat (W) begin
      @(posedge clk); #1;
      check("rst_no_done", done, 0);
      check("rst_no_busy", busy, 0);
    end
    @(negedge clk) rst_n = 1'b1;
    idle_check(2);
    op(8'h0F, 8'h01, 0, 1'b0); idle_check(1);

    // Random operands, sometimes chained back-to-back.
    for (int n = 0; n < 16; n++) begin
      bit chain;
      chain = 1'($urandom_range(0, 1));
      op(W'($urandom), W'($urandom), (n % 3 == 0) ? int'($urandom_range(1, W - 1)) : 0, chain);
      if (!chain) idle_check(int'($urandom_range(1, 3)));
    end
    idle_check(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
